// File: rtl/ldpc_llr_loader.sv
// ldpc_llr_loader: feeds channel LLRs into the LDPC decoder core.
// Incoming samples are quantised and packed into a pending frame buffer.
// A completed frame moves into the registered sig bus as soon as the core can
// take it, so the next frame can fill while the current one decodes.
module ldpc_llr_loader #(
    parameter int data_w = 5,
    parameter int in_w   = 8,
    parameter int SHIFT  = 2,
    parameter int R      = 24,
    parameter int D      = 96,
    parameter int LANES  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [LANES*in_w-1:0]     s_data,
    input  logic                      s_last,
    input  logic                      core_term,
    output logic                      core_en,
    output logic                      core_rst,
    output logic [R*D*data_w-1:0]     sig,
    output logic                      frm_err
);

    localparam int N    = R * D;
    localparam int NB   = N / LANES;
    localparam int CW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int QMAX = 2 ** (data_w - 1) - 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NB - 1);

    // BOOT_LOAD and LAUNCH are the single cycles in which the core takes a new sig
    typedef enum logic [2:0] {
        ST_BOOT,
        ST_BOOT_LOAD,
        ST_RUN,
        ST_LAUNCH,
        ST_IDLE
    } state_t;

    state_t               state_q;
    logic                 pend_full_q;
    logic [CW-1:0]        beat_cnt_q;
    logic [N*data_w-1:0]  pend_q;
    logic [N*data_w-1:0]  sig_q;
    logic                 frm_err_q;
    logic                 accept;
    logic                 xfer;
    logic [data_w-1:0]    lane_llr [LANES];

    // Shift down, then clamp to a symmetric range so the most negative code never appears
    function automatic logic [data_w-1:0] quantise(input logic [in_w-1:0] raw);
        logic signed [in_w-1:0] shifted;
        shifted = $signed(raw) >>> SHIFT;
        if (int'(shifted) > QMAX) begin
            quantise = data_w'(QMAX);
        end else if (int'(shifted) < -QMAX) begin
            quantise = data_w'(-QMAX);
        end else begin
            quantise = shifted[data_w-1:0];
        end
    endfunction

    assign s_ready  = ~pend_full_q;
    assign accept   = s_valid & ~pend_full_q;
    assign xfer     = pend_full_q &&
                      ((state_q == ST_BOOT) || (state_q == ST_IDLE) ||
                       ((state_q == ST_RUN) && core_term));
    assign core_rst = (state_q == ST_BOOT) || (state_q == ST_BOOT_LOAD);
    assign core_en  = (state_q == ST_LAUNCH) || ((state_q == ST_RUN) && !core_term);
    assign sig      = sig_q;
    assign frm_err  = frm_err_q;

    // Quantise every lane of the incoming beat in parallel
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_llr[l] = quantise(s_data[l*in_w +: in_w]);
        end
    end

    // Pack accepted lanes into the pending frame; contents are don't-care until full
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int l = 0; l < LANES; l++) begin
                pend_q[(int'(beat_cnt_q) * LANES + l) * data_w +: data_w] <= lane_llr[l];
            end
        end
    end

    // Beat counting, framing checks and the pending-to-sig handover
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full_q <= 1'b0;
            beat_cnt_q  <= '0;
            sig_q       <= '0;
            frm_err_q   <= 1'b0;
        end else begin
            frm_err_q <= 1'b0;
            if (xfer) begin
                sig_q       <= pend_q;
                pend_full_q <= 1'b0;
            end
            if (accept) begin
                if (beat_cnt_q == LAST_BEAT) begin
                    pend_full_q <= 1'b1;
                    beat_cnt_q  <= '0;
                    frm_err_q   <= ~s_last;
                end else if (s_last) begin
                    beat_cnt_q  <= '0;
                    frm_err_q   <= 1'b1;
                end else begin
                    beat_cnt_q  <= beat_cnt_q + CW'(1);
                end
            end
        end
    end

    // Core control: hold in reset until the first frame lands, then pulse en to load each new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
        end else begin
            case (state_q)
                ST_BOOT:      if (xfer) state_q <= ST_BOOT_LOAD;
                ST_BOOT_LOAD: state_q <= ST_RUN;
                ST_RUN: begin
                    if (core_term) begin
                        state_q <= pend_full_q ? ST_LAUNCH : ST_IDLE;
                    end
                end
                ST_LAUNCH:    state_q <= ST_RUN;
                ST_IDLE:      if (xfer) state_q <= ST_LAUNCH;
                default:      state_q <= ST_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_ldpc_llr_loader.sv
// tb_ldpc_llr_loader: random frames checked against a quantisation reference model,
// plus directed timing checks of the boot, back-to-back, idle, framing and reset cases.
module tb_ldpc_llr_loader;

    localparam int DW    = 5;
    localparam int IW    = 8;
    localparam int SH    = 2;
    localparam int RR    = 24;
    localparam int DD    = 96;
    localparam int LANES = 4;
    localparam int N     = RR * DD;
    localparam int NB    = N / LANES;
    localparam int QMAX  = 2 ** (DW - 1) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 s_valid;
    logic                 s_ready;
    logic [LANES*IW-1:0]  s_data;
    logic                 s_last;
    logic                 core_term;
    logic                 core_en;
    logic                 core_rst;
    logic [N*DW-1:0]      sig;
    logic                 frm_err;

    int errors = 0;
    int checks = 0;
    int samp   [N];
    int qexp   [N];
    int sigExp [N];

    ldpc_llr_loader #(
        .data_w(DW), .in_w(IW), .SHIFT(SH), .R(RR), .D(DD), .LANES(LANES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .core_term(core_term),
        .core_en(core_en), .core_rst(core_rst), .sig(sig), .frm_err(frm_err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Reference quantiser: floor-divide by 2^SHIFT, then clamp symmetrically
    function automatic int quantRef(input int x);
        int div;
        int q;
        div = 1 << SH;
        if (x >= 0) q = x / div;
        else        q = -((-x + div - 1) / div);
        if (q > QMAX)  q = QMAX;
        if (q < -QMAX) q = -QMAX;
        return q;
    endfunction

    function automatic int sigField(input int i);
        logic [DW-1:0] f;
        f = sig[i*DW +: DW];
        return int'($signed(f));
    endfunction

    function automatic int sigMismatches();
        int n = 0;
        for (int i = 0; i < N; i++) if (sigField(i) != sigExp[i]) n++;
        return n;
    endfunction

    task automatic checkOutput(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic genFrame(input bit pinT1);
        for (int i = 0; i < N; i++) samp[i] = int'($urandom_range(0, 255)) - 128;
        if (pinT1) begin
            samp[0] = 127;
            samp[1] = -128;
            samp[2] = 40;
            samp[3] = -3;
        end
        for (int i = 0; i < N; i++) qexp[i] = quantRef(samp[i]);
    endtask

    task automatic driveBeat(input int b, input bit last);
        for (int l = 0; l < LANES; l++) s_data[l*IW +: IW] = IW'(samp[b*LANES + l]);
        s_last  = last;
        s_valid = 1'b1;
    endtask

    // Send beats 0..nBeats-1, s_last on beat lastAt; returns at the negedge after the final accept
    task automatic applyStimulus(input int nBeats, input int lastAt, input bit gaps,
                                 output int errPulses);
        int budget;
        errPulses = 0;
        for (int b = 0; b < nBeats; b++) begin
            @(negedge clk);
            errPulses += int'(frm_err);
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                @(negedge clk);
                errPulses += int'(frm_err);
            end
            budget = 0;
            while (!s_ready && budget < 2000) begin
                s_valid = 1'b0;
                @(negedge clk);
                errPulses += int'(frm_err);
                budget++;
            end
            if (!s_ready) checkOutput("ready_timeout", 0, 1);
            driveBeat(b, b == lastAt);
        end
        @(negedge clk);
        errPulses += int'(frm_err);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Hard stop if the sequence ever stalls
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence
    initial begin
        int p;
        int enHigh;
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        s_data    = '0;
        core_term = 1'b0;
        for (int i = 0; i < N; i++) sigExp[i] = 0;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_s_ready", s_ready, 1);
        checkOutput("rst_core_rst", core_rst, 1);
        checkOutput("rst_core_en", core_en, 0);
        checkOutput("rst_frm_err", frm_err, 0);
        checkOutput("rst_sig_zero", sigMismatches(), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] T1/T2 boot frame");
        genFrame(1'b1);
        applyStimulus(NB, NB - 1, 1'b0, p);
        checkOutput("t2_frm_err", p, 0);
        checkOutput("t2_ready_full", s_ready, 0);
        checkOutput("t2_rst_held", core_rst, 1);
        checkOutput("t2_sig_before", sigMismatches(), 0);
        @(negedge clk);
        sigExp = qexp;
        checkOutput("t2_sig_loaded", sigMismatches(), 0);
        checkOutput("t2_rst_load", core_rst, 1);
        checkOutput("t2_ready_after", s_ready, 1);
        checkOutput("t1_q0", sigField(0), 15);
        checkOutput("t1_q1", sigField(1), -15);
        checkOutput("t1_q2", sigField(2), 10);
        checkOutput("t1_q3", sigField(3), -1);
        @(negedge clk);
        checkOutput("t2_rst_fall", core_rst, 0);
        checkOutput("t2_en_run", core_en, 1);

        $display("[TB] T3 back-to-back");
        genFrame(1'b0);
        applyStimulus(NB, NB - 1, 1'b1, p);
        checkOutput("t3_frm_err", p, 0);
        checkOutput("t3_ready_full", s_ready, 0);
        checkOutput("t3_en_busy", core_en, 1);
        repeat (3) @(negedge clk);
        checkOutput("t3_sig_hold", sigMismatches(), 0);
        core_term = 1'b1;
        #1;
        checkOutput("t3_en_termrise", core_en, 0);
        @(negedge clk);
        sigExp = qexp;
        checkOutput("t3_sig_new", sigMismatches(), 0);
        checkOutput("t3_en_launch", core_en, 1);
        checkOutput("t3_ready_back", s_ready, 1);
        @(negedge clk);
        core_term = 1'b0;
        #1;
        checkOutput("t3_en_run", core_en, 1);
        checkOutput("t3_sig_once", sigMismatches(), 0);

        $display("[TB] T4 idle");
        @(negedge clk);
        core_term = 1'b1;
        #1;
        checkOutput("t4_en_termrise", core_en, 0);
        enHigh = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            #1;
            enHigh += int'(core_en);
        end
        checkOutput("t4_en_idle", enHigh, 0);
        checkOutput("t4_sig_idle", sigMismatches(), 0);
        genFrame(1'b0);
        applyStimulus(NB, NB - 1, 1'b1, p);
        checkOutput("t4_en_xfer", core_en, 0);
        checkOutput("t4_ready_full", s_ready, 0);
        @(negedge clk);
        sigExp = qexp;
        checkOutput("t4_sig_new", sigMismatches(), 0);
        checkOutput("t4_en_launch", core_en, 1);
        @(negedge clk);
        core_term = 1'b0;
        #1;
        checkOutput("t4_en_run", core_en, 1);

        $display("[TB] T5 framing");
        genFrame(1'b0);
        applyStimulus(11, 10, 1'b0, p);
        checkOutput("t5_discard_pulse", p, 1);
        checkOutput("t5_ready_discard", s_ready, 1);
        checkOutput("t5_sig_kept", sigMismatches(), 0);
        genFrame(1'b0);
        applyStimulus(NB, -1, 1'b1, p);
        checkOutput("t5_nolast_pulse", p, 1);
        checkOutput("t5_ready_full", s_ready, 0);
        @(negedge clk);
        checkOutput("t5_pulse_width", frm_err, 0);
        core_term = 1'b1;
        #1;
        checkOutput("t5_en_termrise", core_en, 0);
        @(negedge clk);
        sigExp = qexp;
        checkOutput("t5_sig_aligned", sigMismatches(), 0);
        @(negedge clk);
        core_term = 1'b0;

        $display("[TB] T6 reset mid-frame");
        genFrame(1'b0);
        applyStimulus(300, NB - 1, 1'b0, p);
        driveBeat(300, 1'b0);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) sigExp[i] = 0;
        checkOutput("t6_ready", s_ready, 1);
        checkOutput("t6_core_rst", core_rst, 1);
        checkOutput("t6_core_en", core_en, 0);
        checkOutput("t6_sig_zero", sigMismatches(), 0);
        repeat (2) @(negedge clk);
        s_valid = 1'b0;
        rst_n   = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("t6_rst_hold", core_rst, 1);
        checkOutput("t6_sig_still_zero", sigMismatches(), 0);
        genFrame(1'b0);
        applyStimulus(NB, NB - 1, 1'b1, p);
        checkOutput("t6_ready_full", s_ready, 0);
        @(negedge clk);
        sigExp = qexp;
        checkOutput("t6_sig_new", sigMismatches(), 0);
        checkOutput("t6_rst_load", core_rst, 1);
        @(negedge clk);
        checkOutput("t6_rst_fall", core_rst, 0);
        checkOutput("t6_en_run", core_en, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
